keypad_entry_ctrl: RTL and testbench



---
 rtl/keypad_entry_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// 4x4 keypad scanner, frame-based debouncer and guess-entry controller.
// Define KEYPAD_DUP_REJECT_EN to refuse digits already present in the guess.
module keypad_entry_ctrl #(
   parameter int SCAN_DIV  = 50000,
   parameter int DEB_SCANS = 4,
   parameter int DIGITS    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          keypadCol,
   output logic [3:0]          keypadRow,
   output logic                key_valid,
   output logic [3:0]          key_code,
   output logic [4*DIGITS-1:0] guess,
   output logic [2:0]          guess_len,
   output logic                guess_ready,
   input  logic                guess_ack
);

   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB_N    = 4'(DEB_SCANS);
   localparam logic [2:0]       DIG_N    = 3'(DIGITS);

   typedef enum logic [1:0] {DB_IDLE, DB_CAND, DB_HELD, DB_REL} db_state_t;
   typedef enum logic {EN_ENTRY, EN_READY} en_state_t;

   logic [DIV_W-1:0]    div_q, div_d;
   logic [3:0]          row_q, row_d;
   logic [1:0]          frm_cnt_q, frm_cnt_d;
   logic [3:0]          frm_code_q, frm_code_d;
   db_state_t           db_q, db_d;
   logic [3:0]          deb_cnt_q, deb_cnt_d;
   logic [3:0]          cand_q, cand_d;
   logic                key_valid_q, key_valid_d;
   logic [3:0]          key_code_q, key_code_d;
   en_state_t           en_q, en_d;
   logic [4*DIGITS-1:0] guess_q, guess_d;
   logic [2:0]          len_q, len_d;
   logic                ready_q, ready_d;

   logic       tc, frame_end, frame_hit, dup;
   logic [3:0] frame_code;
   logic [1:0] row_idx, col_idx, base;
   logic [2:0] n_down, sum;
   logic [3:0] samp_code;

   function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h7;  4'h1: k = 4'h4;  4'h2: k = 4'h1;  4'h3: k = 4'h0;
         4'h4: k = 4'h8;  4'h5: k = 4'h5;  4'h6: k = 4'h2;  4'h7: k = 4'hA;
         4'h8: k = 4'h9;  4'h9: k = 4'h6;  4'hA: k = 4'h3;  4'hB: k = 4'hB;
         4'hC: k = 4'hC;  4'hD: k = 4'hD;  4'hE: k = 4'hE;  default: k = 4'hF;
      endcase
      return k;
   endfunction

   // Scan divider, row rotation and per-frame key accumulation.
   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      tc         = (div_q == DIV_LAST);
      div_d      = tc ? '0 : div_q + DIV_W'(1);
      row_d      = row_q;
      frm_cnt_d  = frm_cnt_q;
      frm_code_d = frm_code_q;
      frame_end  = 1'b0;
      frame_hit  = 1'b0;
      frame_code = frm_code_q;

      case (row_q)
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase

      n_down  = 3'd0;
      col_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!keypadCol[i]) begin
            n_down  = n_down + 3'd1;
            col_idx = 2'(i);
         end
      end
      samp_code = decode(row_idx, col_idx);
      base      = (row_q == 4'b1110) ? 2'd0 : frm_cnt_q;
      sum       = {1'b0, base} + n_down;

      if (tc) begin
         frm_cnt_d  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
         frm_code_d = (n_down == 3'd1) ? samp_code : frm_code_q;
         case (row_q)
            4'b1110: row_d = 4'b1101;
            4'b1101: row_d = 4'b1011;
            4'b1011: row_d = 4'b0111;
            default: row_d = 4'b1110;
         endcase
         frame_end  = (row_q == 4'b0111);
         frame_hit  = (frm_cnt_d == 2'd1);
         frame_code = frm_code_d;
      end
   end

   // Debounce: one step per completed frame; a ghost frame counts as no key.
   always_comb begin
      db_d        = db_q;
      deb_cnt_d   = deb_cnt_q;
      cand_d      = cand_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      if (frame_end) begin
         case (db_q)
            DB_IDLE: if (frame_hit) begin
               cand_d = frame_code;
               if (DEB_N == 4'd1) begin
                  key_valid_d = 1'b1;
                  key_code_d  = frame_code;
                  db_d        = DB_HELD;
               end else begin
                  deb_cnt_d = 4'd1;
                  db_d      = DB_CAND;
               end
            end
            DB_CAND: if (frame_hit && frame_code == cand_q) begin
               if (deb_cnt_q + 4'd1 == DEB_N) begin
                  key_valid_d = 1'b1;
                  key_code_d  = cand_q;
                  db_d        = DB_HELD;
               end else begin
                  deb_cnt_d = deb_cnt_q + 4'd1;
               end
            end else begin
               db_d = DB_IDLE;
            end
            DB_HELD: if (!frame_hit) begin
               deb_cnt_d = 4'd1;
               db_d      = (DEB_N == 4'd1) ? DB_IDLE : DB_REL;
            end
            default: if (frame_hit) begin
               db_d = DB_HELD;
            end else if (deb_cnt_q + 4'd1 == DEB_N) begin
               db_d = DB_IDLE;
            end else begin
               deb_cnt_d = deb_cnt_q + 4'd1;
            end
         endcase
      end
   end

`ifdef KEYPAD_DUP_REJECT_EN
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (3'(i) < len_q && guess_q[4*i +: 4] == key_code_q) dup = 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Entry: digits shift in at the low nibble; ack in READY takes priority over keys.
   always_comb begin
      en_d    = en_q;
      guess_d = guess_q;
      len_d   = len_q;
      ready_d = ready_q;
      case (en_q)
         EN_ENTRY: if (key_valid_q) begin
            if (key_code_q <= 4'd9) begin
               if (len_q < DIG_N && !dup) begin
                  guess_d = (guess_q << 4) | (4*DIGITS)'(key_code_q);
                  len_d   = len_q + 3'd1;
               end
            end else if (key_code_q == 4'hA) begin
               guess_d = '0;
               len_d   = 3'd0;
            end else if (key_code_q == 4'hB && len_q == DIG_N) begin
               ready_d = 1'b1;
               en_d    = EN_READY;
            end
         end
         default: if (guess_ack) begin
            guess_d = '0;
            len_d   = 3'd0;
            ready_d = 1'b0;
            en_d    = EN_ENTRY;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q       <= '0;
         row_q       <= 4'b1110;
         frm_cnt_q   <= 2'd0;
         frm_code_q  <= 4'd0;
         db_q        <= DB_IDLE;
         deb_cnt_q   <= 4'd0;
         cand_q      <= 4'd0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'd0;
         en_q        <= EN_ENTRY;
         guess_q     <= '0;
         len_q       <= 3'd0;
         ready_q     <= 1'b0;
      end else begin
         div_q       <= div_d;
         row_q       <= row_d;
         frm_cnt_q   <= frm_cnt_d;
         frm_code_q  <= frm_code_d;
         db_q        <= db_d;
         deb_cnt_q   <= deb_cnt_d;
         cand_q      <= cand_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         en_q        <= en_d;
         guess_q     <= guess_d;
         len_q       <= len_d;
         ready_q     <= ready_d;
      end
   end

   assign keypadRow   = row_q;
   assign key_valid   = key_valid_q;
   assign key_code    = key_code_q;
   assign guess       = guess_q;
   assign guess_len   = len_q;
   assign guess_ready = ready_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: keypad matrix model, key-event
// scoreboard and a table of entry steps with expected guess state.
module tb_keypad_entry_ctrl;

   localparam int SCAN_DIV  = 4;
   localparam int DEB_SCANS = 2;
   localparam int DIGITS    = 4;
   localparam int FRAME     = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  keypadCol;
   logic [3:0]  keypadRow;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] guess;
   logic [2:0]  guess_len;
   logic        guess_ready;
   logic        guess_ack;

   logic [15:0] pressed;
   logic [3:0]  exp_q[$];
   int          pulse_cnt = 0;
   int          chk_cnt   = 0;
   int          pass_cnt  = 0;

   typedef struct {
      logic [3:0]  key;
      logic [15:0] exp_guess;
      logic [2:0]  exp_len;
      logic        exp_ready;
   } entry_vec_t;

   entry_vec_t vecs[14];

   keypad_entry_ctrl #(
      .SCAN_DIV (SCAN_DIV),
      .DEB_SCANS(DEB_SCANS),
      .DIGITS   (DIGITS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .keypadCol  (keypadCol),
      .keypadRow  (keypadRow),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .guess      (guess),
      .guess_len  (guess_len),
      .guess_ready(guess_ready),
      .guess_ack  (guess_ack)
   );

   always #5 clk = ~clk;

   // Key position on the matrix as {row index, column index}.
   function automatic logic [3:0] key_pos(input int k);
      logic [3:0] p;
      case (k)
         0: p = 4'b00_11;  1: p = 4'b00_10;  2: p = 4'b01_10;  3: p = 4'b10_10;
         4: p = 4'b00_01;  5: p = 4'b01_01;  6: p = 4'b10_01;  7: p = 4'b00_00;
         8: p = 4'b01_00;  9: p = 4'b10_00;  10: p = 4'b01_11; 11: p = 4'b10_11;
         12: p = 4'b11_00; 13: p = 4'b11_01; 14: p = 4'b11_10; default: p = 4'b11_11;
      endcase
      return p;
   endfunction

   always_comb begin
      keypadCol = 4'hF;
      for (int k = 0; k < 16; k++) begin
         if (pressed[k] && keypadRow == ~(4'b0001 << key_pos(k)[3:2]))
            keypadCol = keypadCol & ~(4'b0001 << key_pos(k)[1:0]);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard: every key_valid pulse must match the next expected key code.
   always @(negedge clk) begin
      if (rst === 1'b0 && key_valid === 1'b1) begin
         pulse_cnt++;
         if (exp_q.size() == 0) check("unexpected_key_valid", {28'd0, key_code}, 32'hFFFF_FFFF);
         else check("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
      end
   end

   task automatic press_key(input logic [3:0] code);
      int start;
      bit seen;
      start = pulse_cnt;
      seen  = 1'b0;
      exp_q.push_back(code);
      pressed = 16'd1 << code;
      for (int i = 0; i < 8 * FRAME; i++) begin
         @(negedge clk);
         #1;
         if (pulse_cnt != start) begin
            seen = 1'b1;
            break;
         end
      end
      check("press_seen", {31'd0, seen}, 32'd1);
      if (!seen) void'(exp_q.pop_back());
      @(negedge clk);
      #1;
   endtask

   task automatic release_key();
      pressed = 16'd0;
      repeat (4 * FRAME + 4) @(negedge clk);
   endtask

   task automatic apply_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         press_key(vecs[i].key);
         check($sformatf("guess[%0d]", i), {16'd0, guess}, {16'd0, vecs[i].exp_guess});
         check($sformatf("len[%0d]", i), {29'd0, guess_len}, {29'd0, vecs[i].exp_len});
         check($sformatf("ready[%0d]", i), {31'd0, guess_ready}, {31'd0, vecs[i].exp_ready});
         release_key();
      end
   endtask

   initial begin
      int  start;
      bit  found;

      vecs[0]  = '{4'h1, 16'h0001, 3'd1, 1'b0};
      vecs[1]  = '{4'h2, 16'h0012, 3'd2, 1'b0};
      vecs[2]  = '{4'h3, 16'h0123, 3'd3, 1'b0};
      vecs[3]  = '{4'h4, 16'h1234, 3'd4, 1'b0};
      vecs[4]  = '{4'h9, 16'h1234, 3'd4, 1'b0};
      vecs[5]  = '{4'hB, 16'h1234, 3'd4, 1'b1};
      vecs[6]  = '{4'h5, 16'h1234, 3'd4, 1'b1};
      vecs[7]  = '{4'h7, 16'h0007, 3'd1, 1'b0};
      vecs[8]  = '{4'h8, 16'h0078, 3'd2, 1'b0};
      vecs[9]  = '{4'hB, 16'h0078, 3'd2, 1'b0};
      vecs[10] = '{4'hA, 16'h0000, 3'd0, 1'b0};
      vecs[11] = '{4'h3, 16'h0003, 3'd1, 1'b0};
`ifdef KEYPAD_DUP_REJECT_EN
      vecs[12] = '{4'h3, 16'h0003, 3'd1, 1'b0};
      vecs[13] = '{4'h4, 16'h0034, 3'd2, 1'b0};
`else
      vecs[12] = '{4'h3, 16'h0033, 3'd2, 1'b0};
      vecs[13] = '{4'h4, 16'h0334, 3'd3, 1'b0};
`endif

      pressed   = 16'd0;
      guess_ack = 1'b0;
      rst       = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_row", {28'd0, keypadRow}, 32'hE);
      check("rst_key_valid", {31'd0, key_valid}, 32'd0);
      check("rst_key_code", {28'd0, key_code}, 32'd0);
      check("rst_guess", {16'd0, guess}, 32'd0);
      check("rst_len", {29'd0, guess_len}, 32'd0);
      check("rst_ready", {31'd0, guess_ready}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Single key 2 held for many frames: exactly one event.
      start = pulse_cnt;
      exp_q.push_back(4'h2);
      pressed = 16'h0004;
      repeat (4 * FRAME) @(negedge clk);
      #1;
      check("single_pulse", pulse_cnt - start, 32'd1);
      check("single_guess", {16'd0, guess}, 32'h0002);
      check("single_len", {29'd0, guess_len}, 32'd1);
      repeat (10 * FRAME) @(negedge clk);
      #1;
      check("held_no_repeat", pulse_cnt - start, 32'd1);
      release_key();
      press_key(4'hA);
      check("clear_guess", {16'd0, guess}, 32'd0);
      release_key();

      // Bouncing key 5, then ghosting pair 7+8: no events either way.
      start = pulse_cnt;
      for (int n = 0; n < 5; n++) begin
         pressed = 16'h0020;
         repeat (FRAME) @(negedge clk);
         pressed = 16'd0;
         repeat (FRAME) @(negedge clk);
      end
      repeat (4 * FRAME) @(negedge clk);
      #1;
      check("bounce_no_pulse", pulse_cnt - start, 32'd0);
      pressed = 16'h0180;
      repeat (6 * FRAME) @(negedge clk);
      pressed = 16'd0;
      repeat (4 * FRAME) @(negedge clk);
      #1;
      check("ghost_no_pulse", pulse_cnt - start, 32'd0);

      // Full guess, overflow digit, enter, ignored key in READY, then ack.
      apply_range(0, 6);
      @(negedge clk);
      guess_ack = 1'b1;
      @(negedge clk);
      guess_ack = 1'b0;
      #1;
      check("ack_guess", {16'd0, guess}, 32'd0);
      check("ack_len", {29'd0, guess_len}, 32'd0);
      check("ack_ready", {31'd0, guess_ready}, 32'd0);

      // Early enter and clear, then the duplicate-digit sequence.
      apply_range(7, 10);
      apply_range(11, 13);
      press_key(4'hA);
      release_key();

      // Ack outside READY is ignored; async reset mid-entry and mid-scan.
      press_key(4'h7);
      release_key();
      press_key(4'h8);
      release_key();
      @(negedge clk);
      guess_ack = 1'b1;
      @(negedge clk);
      guess_ack = 1'b0;
      #1;
      check("stray_ack_guess", {16'd0, guess}, 32'h0078);
      check("stray_ack_len", {29'd0, guess_len}, 32'd2);
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (keypadRow == 4'b1011) begin
            found = 1'b1;
            break;
         end
      end
      check("row_reached", {31'd0, found}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_row", {28'd0, keypadRow}, 32'hE);
      check("async_rst_guess", {16'd0, guess}, 32'd0);
      check("async_rst_len", {29'd0, guess_len}, 32'd0);
      check("async_rst_valid", {31'd0, key_valid}, 32'd0);
      check("async_rst_ready", {31'd0, guess_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      press_key(4'h1);
      check("post_rst_guess", {16'd0, guess}, 32'h0001);
      check("post_rst_len", {29'd0, guess_len}, 32'd1);
      release_key();

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
